// File: rtl/fetch_unit.sv
// fetch_unit: SAYEH instruction fetch sequencer.
// It takes the PC, issues a memory read, and captures the returned word into
// the instruction register. It then hands the word to the controller and
// strobes pc_next into the program counter. A wait-state limit flags a
// memory that never answers.
//
// Handshakes:
//   memory side     - read_mem/addr_bus stay high and stable until mem_ready is
//                     seen in BUSY. mem_ready at any other time is ignored.
//   controller side - ir_valid stays high with ir_out stable until ir_ack;
//                     the word moves on the cycle ir_valid && ir_ack.
//
// fsm_state exposes the sequencer state for observation:
//   0 = IDLE, 1 = BUSY, 2 = HOLD.
module fetch_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_start,
    input  logic        flush,
    input  logic [15:0] pc_in,
    input  logic [15:0] mem_data_in,
    input  logic        mem_ready,
    input  logic        ir_ack,
    output logic [15:0] addr_bus,
    output logic        read_mem,
    output logic [15:0] ir_out,
    output logic        ir_valid,
    output logic [15:0] pc_next,
    output logic        pc_enable,
    output logic        fetch_error,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Last wait-counter value before the read is abandoned.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic        read_q, read_d;
    logic [15:0] ir_q, ir_d;
    logic        ir_valid_q, ir_valid_d;
    logic [15:0] pc_next_q, pc_next_d;
    logic        pc_en_q, pc_en_d;
    logic        err_q, err_d;
    logic [7:0]  wait_q, wait_d;

    // Next-state and next-output logic; flush overrides every other input.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        read_d     = read_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        pc_next_d  = pc_next_q;
        pc_en_d    = 1'b0;
        err_d      = err_q;
        wait_d     = wait_q;

        if (flush) begin
            state_d    = IDLE;
            read_d     = 1'b0;
            ir_valid_d = 1'b0;
            err_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fetch_start) begin
                        addr_d  = pc_in;
                        read_d  = 1'b1;
                        wait_d  = 8'd0;
                        err_d   = 1'b0;
                        state_d = BUSY;
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        ir_d       = mem_data_in;
                        pc_next_d  = addr_q + 16'd1;
                        pc_en_d    = 1'b1;
                        ir_valid_d = 1'b1;
                        read_d     = 1'b0;
                        state_d    = HOLD;
                    end else if (wait_q == WAIT_LAST) begin
                        err_d   = 1'b1;
                        read_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end
                HOLD: begin
                    if (ir_ack) begin
                        ir_valid_d = 1'b0;
                        if (fetch_start) begin
                            addr_d  = pc_in;
                            read_d  = 1'b1;
                            wait_d  = 8'd0;
                            err_d   = 1'b0;
                            state_d = BUSY;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    read_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers; reset clears read_mem without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= 16'h0000;
            read_q     <= 1'b0;
            ir_q       <= 16'h0000;
            ir_valid_q <= 1'b0;
            pc_next_q  <= 16'h0000;
            pc_en_q    <= 1'b0;
            err_q      <= 1'b0;
            wait_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            read_q     <= read_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            pc_next_q  <= pc_next_d;
            pc_en_q    <= pc_en_d;
            err_q      <= err_d;
            wait_q     <= wait_d;
        end
    end

    assign addr_bus    = addr_q;
    assign read_mem    = read_q;
    assign ir_out      = ir_q;
    assign ir_valid    = ir_valid_q;
    assign pc_next     = pc_next_q;
    assign pc_enable   = pc_en_q;
    assign fetch_error = err_q;
    assign fsm_state   = state_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer for the SAYEH CPU and the consumer of the program counter's output. It samples the current PC value, issues a read on the shared memory bus, and captures the returned word into an instruction register. It then hands the word to the controller with a valid/ack handshake and produces the incremented address plus a one-cycle load-enable that writes the program counter back. A wait-state timeout flags a memory that never answers.

## Interface
- TIMEOUT, 16: maximum number of cycles a read may stay outstanding; legal range 2..255.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- fetch_start  in  1  controller request to fetch at `pc_in`; sampled only in IDLE or HOLD.
- flush  in  1  synchronous abort; has priority over every other input except `rst`.
- pc_in  in  16  current program counter output.
- mem_data_in  in  16  read data from memory, valid while `mem_ready`=1.
- mem_ready  in  1  memory read-complete strobe.
- ir_ack  in  1  controller has consumed `ir_out`.
- addr_bus  out  16  fetch address, registered.
- read_mem  out  1  memory read request, registered.
- ir_out  out  16  captured instruction word.
- ir_valid  out  1  `ir_out` holds an unconsumed instruction.
- pc_next  out  16  captured address + 1, to the program counter input.
- pc_enable  out  1  one-cycle load strobe for the program counter.
- fetch_error  out  1  sticky timeout flag.

## Operation
- Reset values:
  - state = IDLE.
  - `addr_bus`, `ir_out`, `pc_next` = 16'h0000.
  - `read_mem`, `ir_valid`, `pc_enable`, `fetch_error` = 0.
  - Wait counter = 0.
- States are IDLE, BUSY and HOLD. All transitions occur on the rising edge of `clk`.
- IDLE:
  - If `fetch_start`=1: `addr_bus`<=`pc_in`, `read_mem`<=1, wait counter<=0, go to BUSY.
  - Starting a fetch clears `fetch_error`.
- BUSY: `read_mem` stays 1 and `addr_bus` is held constant.
  - If `mem_ready`=1: `ir_out`<=`mem_data_in`, `pc_next`<=`addr_bus`+1 (16-bit, FFFF wraps to 0000), `pc_enable`<=1 for exactly one cycle, `ir_valid`<=1, `read_mem`<=0, go to HOLD.
  - Else if wait counter = TIMEOUT-1: `fetch_error`<=1, `read_mem`<=0, go to IDLE. `ir_out`, `pc_next` and `pc_enable` are unchanged.
  - Else: wait counter increments.
- HOLD: `ir_valid`=1 and `ir_out` is stable.
  - `ir_ack`=1 and `fetch_start`=1: clear `ir_valid` and start the next fetch exactly as from IDLE, going to BUSY (back-to-back fetch).
  - `ir_ack`=1 only: clear `ir_valid`, go to IDLE.
  - `fetch_start` without `ir_ack`: ignored; the instruction is not overwritten.
- In BUSY, `fetch_start` and `ir_ack` are ignored.
- `mem_ready` outside BUSY is ignored.
- `flush`=1 in any state: go to IDLE with `read_mem`, `ir_valid`, `pc_enable` and `fetch_error` cleared.
  - `ir_out` and `pc_next` are retained.
  - A `mem_ready` in the same cycle is discarded.
- `rst` asserted mid-read drops `read_mem` immediately (asynchronously) and returns all outputs to their reset values.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Minimum fetch:
  - `fetch_start` sampled at edge 0, so `read_mem`=1 after edge 0.
  - `mem_ready` sampled at edge 1, so `ir_valid`=1 and `pc_enable`=1 after edge 1, and `read_mem`=0.
  - Two edges from request to instruction.
- Each wait state adds one cycle.
- Timeout: with no `mem_ready`, `read_mem` is high for exactly TIMEOUT cycles. `fetch_error` rises on the same edge that `read_mem` falls.
- `pc_enable` is high for one cycle and coincides with the first cycle of `ir_valid`. The program counter therefore updates on the following edge.
- Back-to-back: `ir_ack`+`fetch_start` at edge N puts `read_mem` high after edge N. Sustained throughput is one instruction per 2 cycles with zero wait states.

## Test plan
- Reset, then `pc_in`=16'h0040, `fetch_start` pulse, `mem_ready`=1 with `mem_data_in`=16'h1234 on the next edge. Required: `addr_bus`=0040, `read_mem` high for 1 cycle, `ir_out`=1234, `pc_next`=0041, `pc_enable` high for 1 cycle, `ir_valid` high until `ir_ack`.
- 3 wait states at `pc_in`=16'hFFFF, data 16'hABCD. Required: `read_mem` high for 4 cycles with `addr_bus` stable, `pc_next`=16'h0000 (wrap), `ir_out`=ABCD.
- TIMEOUT=4 with `mem_ready` held 0. Required: `read_mem` high exactly 4 cycles, then `fetch_error`=1, state IDLE, `ir_valid`=0. The next `fetch_start` clears `fetch_error`.
- In HOLD, `fetch_start` without `ir_ack` for 3 cycles. Required: `ir_out` unchanged and no new read. Then `ir_ack`+`fetch_start` together with `pc_in`=0041. Required: `read_mem`=1 with `addr_bus`=0041 on the next cycle.
- `flush` in BUSY in the same cycle as `mem_ready`. Required: `ir_valid`=0, `pc_enable`=0, `read_mem`=0, `ir_out` unchanged.
- `rst` asserted mid-cycle during BUSY. Required: `read_mem` drops before the next clock edge and all outputs return to reset values.
